// File: rtl/if_hazard_ctrl.sv
// ID-stage fetch controller: load-use interlock against a shadow ID/EX record,
// BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL resolution in ID, wrong-path squash, stall/flush counters.
module if_hazard_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instruction_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            pc_load,
  output logic            if_id_load,
  output logic            mux3_selector,
  output logic [XLEN-1:0] pc_branch_in,
  output logic            id_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    RUN,
    SQUASH
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sq_cnt_q, sq_cnt_d;
  logic             ex_mem_read_q, ex_mem_read_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            uses_rs1, uses_rs2, hazard, br_cond, taken;
  logic [XLEN-1:0] imm_b, imm_j, target;
  logic            stall_inc, flush_inc;

  assign opcode = instruction_in[6:0];
  assign rd     = instruction_in[11:7];
  assign funct3 = instruction_in[14:12];
  assign rs1    = instruction_in[19:15];
  assign rs2    = instruction_in[24:20];

  assign uses_rs1 = opcode inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG, OP_JALR};
  assign uses_rs2 = opcode inside {OP_STORE, OP_BRANCH, OP_REG};

  assign hazard = ex_mem_read_q && (ex_rd_q != '0) &&
                  ((uses_rs1 && (rs1 == ex_rd_q)) || (uses_rs2 && (rs2 == ex_rd_q)));

  assign imm_b = {{(XLEN-12){instruction_in[31]}}, instruction_in[7],
                  instruction_in[30:25], instruction_in[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){instruction_in[31]}}, instruction_in[19:12],
                  instruction_in[20], instruction_in[30:21], 1'b0};

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = (rs1_data == rs2_data);
      3'b001:  br_cond = (rs1_data != rs2_data);
      3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_cond = (rs1_data <  rs2_data);
      3'b111:  br_cond = (rs1_data >= rs2_data);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = (opcode == OP_JAL) || ((opcode == OP_BRANCH) && br_cond);
  assign target = pc_in + ((opcode == OP_JAL) ? imm_j : imm_b);

  always_comb begin
    state_d       = state_q;
    sq_cnt_d      = sq_cnt_q;
    ex_mem_read_d = ex_mem_read_q;
    ex_rd_d       = ex_rd_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_load       = 1'b1;
    if_id_load    = 1'b1;
    mux3_selector = 1'b0;
    pc_branch_in  = '0;
    id_bubble     = 1'b0;

    case (state_q)
      RUN: begin
        if (hazard) begin
          // Branch evaluation waits: operands become forwardable next cycle.
          pc_load       = 1'b0;
          if_id_load    = 1'b0;
          id_bubble     = 1'b1;
          ex_mem_read_d = 1'b0;
          ex_rd_d       = '0;
          stall_inc     = 1'b1;
        end else begin
          ex_mem_read_d = (opcode == OP_LOAD);
          ex_rd_d       = rd;
          if (taken) begin
            mux3_selector = 1'b1;
            pc_branch_in  = target;
            state_d       = SQUASH;
            sq_cnt_d      = 3'(FLUSH_CYCLES);
            flush_inc     = 1'b1;
          end
        end
      end
      SQUASH: begin
        id_bubble     = 1'b1;
        ex_mem_read_d = 1'b0;
        ex_rd_d       = '0;
        sq_cnt_d      = sq_cnt_q - 3'd1;
        if (sq_cnt_q == 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (reset) begin
      pc_load       = 1'b1;
      if_id_load    = 1'b1;
      mux3_selector = 1'b0;
      pc_branch_in  = '0;
      id_bubble     = 1'b0;
    end
  end

  assign stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      sq_cnt_q      <= '0;
      ex_mem_read_q <= 1'b0;
      ex_rd_q       <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      sq_cnt_q      <= sq_cnt_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_rd_q       <= ex_rd_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Bench for if_hazard_ctrl: two instances (default, and FLUSH_CYCLES=3/CNT_W=2) driven
// in lockstep, each checked against an instruction-level reference model.
module tb_if_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0, instruction_in = 32'h00000013, rs1_data = '0, rs2_data = '0;

  logic        pl0, il0, ms0, ib0, pl1, il1, ms1, ib1;
  logic [31:0] pb0, pb1;
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  if_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut0 (
    .clock(clock), .reset(reset), .pc_in(pc_in), .instruction_in(instruction_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc_load(pl0), .if_id_load(il0),
    .mux3_selector(ms0), .pc_branch_in(pb0), .id_bubble(ib0),
    .stall_count(sc0), .flush_count(fc0));

  if_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(3), .CNT_W(2)) u_dut1 (
    .clock(clock), .reset(reset), .pc_in(pc_in), .instruction_in(instruction_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc_load(pl1), .if_id_load(il1),
    .mux3_selector(ms1), .pc_branch_in(pb1), .id_bubble(ib1),
    .stall_count(sc1), .flush_count(fc1));

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: remaining squash slots, last issued instruction's (is_load, rd), counters.
  int fcyc[2] = '{1, 3};
  int cmax[2] = '{65535, 3};
  int sq_left[2], sh_rd[2], stalls[2], flushes[2];
  bit sh_ld[2];
  int n_sq[2], n_rd[2], n_st[2], n_fl[2];
  bit n_ld[2];

  bit          last_ms0;
  logic [31:0] last_pb0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sq_left[k] = 0; sh_ld[k] = 0; sh_rd[k] = 0; stalls[k] = 0; flushes[k] = 0;
    end
  endtask

  task automatic model_eval(input int k, output bit e_pl, output bit e_il, output bit e_ms,
                            output bit e_ib, output logic [31:0] e_pb);
    logic [31:0] ins;
    logic [6:0]  op;
    int          rd, f3, s1, s2;
    bit          u1, u2, haz, tk;
    longint      imm;
    ins = instruction_in;
    op = ins[6:0]; rd = int'(ins[11:7]); f3 = int'(ins[14:12]);
    s1 = int'(ins[19:15]); s2 = int'(ins[24:20]);
    e_pl = 1; e_il = 1; e_ms = 0; e_ib = 0; e_pb = '0;
    n_sq[k] = sq_left[k]; n_ld[k] = sh_ld[k]; n_rd[k] = sh_rd[k];
    n_st[k] = stalls[k]; n_fl[k] = flushes[k];
    if (reset) begin
      n_sq[k] = 0; n_ld[k] = 0; n_rd[k] = 0; n_st[k] = 0; n_fl[k] = 0;
    end else if (sq_left[k] > 0) begin
      e_ib = 1; n_sq[k] = sq_left[k] - 1; n_ld[k] = 0; n_rd[k] = 0;
    end else begin
      u1 = op inside {7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011, 7'b1100111};
      u2 = op inside {7'b0100011, 7'b1100011, 7'b0110011};
      haz = sh_ld[k] && sh_rd[k] != 0 && ((u1 && s1 == sh_rd[k]) || (u2 && s2 == sh_rd[k]));
      if (haz) begin
        e_pl = 0; e_il = 0; e_ib = 1; n_ld[k] = 0; n_rd[k] = 0;
        n_st[k] = (stalls[k] + 1 > cmax[k]) ? cmax[k] : stalls[k] + 1;
      end else begin
        tk = 0; imm = 0;
        if (op == 7'b1101111) begin
          tk = 1;
          imm = ins[31] ? -64'sd1048576 : 0;
          imm += longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        end else if (op == 7'b1100011) begin
          case (f3)
            0: tk = (rs1_data == rs2_data);
            1: tk = (rs1_data != rs2_data);
            4: tk = ($signed(rs1_data) <  $signed(rs2_data));
            5: tk = ($signed(rs1_data) >= $signed(rs2_data));
            6: tk = (rs1_data <  rs2_data);
            7: tk = (rs1_data >= rs2_data);
            default: tk = 0;
          endcase
          imm = ins[31] ? -64'sd4096 : 0;
          imm += longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        end
        n_ld[k] = (op == 7'b0000011); n_rd[k] = rd;
        if (tk) begin
          e_ms = 1; e_pb = 32'(longint'(pc_in) + imm);
          n_sq[k] = fcyc[k];
          n_fl[k] = (flushes[k] + 1 > cmax[k]) ? cmax[k] : flushes[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    bit e_pl, e_il, e_ms, e_ib;
    logic [31:0] e_pb;
    model_eval(0, e_pl, e_il, e_ms, e_ib, e_pb);
    check("pc_load0", pl0, e_pl);       check("if_id_load0", il0, e_il);
    check("mux3_sel0", ms0, e_ms);      check("branch_pc0", pb0, e_pb);
    check("id_bubble0", ib0, e_ib);
    check("stall_cnt0", sc0, stalls[0]); check("flush_cnt0", fc0, flushes[0]);
    last_ms0 = ms0; last_pb0 = pb0;
    model_eval(1, e_pl, e_il, e_ms, e_ib, e_pb);
    check("pc_load1", pl1, e_pl);       check("if_id_load1", il1, e_il);
    check("mux3_sel1", ms1, e_ms);      check("branch_pc1", pb1, e_pb);
    check("id_bubble1", ib1, e_ib);
    check("stall_cnt1", sc1, stalls[1]); check("flush_cnt1", fc1, flushes[1]);
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    instruction_in = ins; pc_in = pc; rs1_data = a; rs2_data = b;
    @(negedge clock);
    check_all();
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      sq_left[k] = n_sq[k]; sh_ld[k] = n_ld[k]; sh_rd[k] = n_rd[k];
      stalls[k] = n_st[k]; flushes[k] = n_fl[k];
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_reset();
    repeat (n) apply($urandom, $urandom, $urandom, $urandom);
    reset = 1'b0;
  endtask

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00228333;

  logic [6:0]  ops[9] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1100011, 7'b0010011,
                          7'b0110011, 7'b1100111, 7'b1101111, 7'b0110111};
  logic [31:0] vals[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7};

  initial begin
    logic [31:0] ins;
    model_reset();
    do_reset(5);

    apply(LW5, 32'h0, 0, 0);
    apply(ADD6, 32'h4, 0, 0);
    apply(ADD6, 32'h4, 0, 0);
    apply(32'h00008003, 32'h8, 0, 0);
    apply(32'h00200333, 32'hC, 0, 0);

    // Reset mid-sequence right after a load: the following dependent add must not stall.
    apply(LW5, 32'h10, 0, 0);
    do_reset(5);
    apply(ADD6, 32'h14, 0, 0);

    apply(32'h00208863, 32'h20, 7, 7);
    check("beq_taken", last_ms0, 1'b1);
    check("beq_target", last_pb0, 32'h30);
    repeat (3) apply(NOP, 32'h30, 0, 0);
    apply(32'h00208863, 32'h20, 7, 8);
    check("beq_not_taken", last_ms0, 1'b0);
    apply(32'h0020C863, 32'h24, 32'hFFFFFFFF, 1);
    check("blt_taken", last_ms0, 1'b1);
    repeat (3) apply(NOP, 32'h34, 0, 0);
    apply(32'h0020E863, 32'h28, 32'hFFFFFFFF, 1);
    check("bltu_not_taken", last_ms0, 1'b0);

    apply(32'hFF9FF06F, 32'h100, 0, 0);
    check("jal_target", last_pb0, 32'hF8);
    repeat (3) apply(LW5, 32'hF8, 0, 0);
    apply(ADD6, 32'hFC, 0, 0);
    apply(ADD6, 32'hFC, 0, 0);

    // Mid-squash reset.
    apply(32'hFF9FF06F, 32'h200, 0, 0);
    do_reset(2);
    apply(NOP, 32'h0, 0, 0);

    do_reset(2);
    repeat (5) begin
      apply(LW5, 32'h40, 0, 0);
      apply(ADD6, 32'h44, 0, 0);
      apply(ADD6, 32'h44, 0, 0);
    end
    check("stall_sat1", sc1, 2'd3);
    check("stall_cnt0_after5", sc0, 16'd5);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 3)));
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      apply(ins, $urandom & 32'hFFFFFFFC, vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_hazard_ctrl.md
Name: if_hazard_ctrl

Overview:
- Consumer-side controller for the instruction fetch stage.
- Sits in ID: decodes the instruction held in IF/ID (instruction_out, pc_out) and drives the fetch control inputs pc_load, if_id_load, mux3_selector and pc_branch_in.
- Detects load-use hazards against a shadow ID/EX record, resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL in ID, and squashes wrong-path instructions.
- Keeps saturating stall and flush counters.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 1, number of wrong-path IF/ID instructions squashed after a redirect (1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_in  in  XLEN  pc_out of fetch (PC of the instruction in IF/ID).
- instruction_in  in  32  instruction_out of fetch.
- rs1_data  in  XLEN  register file read of instruction_in[19:15].
- rs2_data  in  XLEN  register file read of instruction_in[24:20].
- pc_load  out  1  PC write enable to fetch.
- if_id_load  out  1  IF/ID write enable to fetch.
- mux3_selector  out  1  1 = fetch takes pc_branch_in.
- pc_branch_in  out  XLEN  redirect target.
- id_bubble  out  1  1 = ID must issue a NOP into ID/EX this cycle.
- stall_count  out  CNT_W  cycles stalled on load-use.
- flush_count  out  CNT_W  redirects taken.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State RUN, squash counter 0.
  - Shadow ex_mem_read=0, ex_rd=0.
  - Both counters 0.
  - While reset is high, outputs are forced to pc_load=1, if_id_load=1, mux3_selector=0, pc_branch_in=0, id_bubble=0.
- Outputs are combinational from state, shadow registers and inputs; only state, shadow registers and counters are registered.
- Decode fields:
  - opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20].
  - Uses rs1: opcodes 0000011, 0100011, 1100011, 0010011, 0110011, 1100111.
  - Uses rs2: 0100011, 1100011, 0110011.
  - JALR is not redirected here.
- hazard = ex_mem_read & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- RUN state:
  - If hazard: pc_load=0, if_id_load=0, id_bubble=1, mux3_selector=0. At the edge, shadow is set to (0,0) and stall_count increments. Branch evaluation is suppressed this cycle.
  - Else if taken (JAL, or BRANCH whose funct3 condition holds; funct3 010/011 never taken):
    - mux3_selector=1.
    - pc_branch_in = pc_in + imm, modulo 2^XLEN.
    - B-imm = sext({i[31],i[7],i[30:25],i[11:8],0}); J-imm = sext({i[31],i[19:12],i[20],i[30:21],0}).
    - pc_load=1, if_id_load=1.
    - At the edge: shadow captures (opcode==0000011, rd), go to SQUASH, squash counter = FLUSH_CYCLES, flush_count increments.
  - Else: pc_load=1, if_id_load=1, mux3_selector=0, pc_branch_in=0. Shadow captures (opcode==0000011, rd).
- Comparisons: signed for BLT/BGE, unsigned for BLTU/BGEU.
- SQUASH state:
  - instruction_in is ignored: no hazard, no branch.
  - id_bubble=1, pc_load=1, if_id_load=1, mux3_selector=0; shadow set to (0,0).
  - Counter decrements; return to RUN when it reaches 0 at this edge.
- Counters saturate at all ones and never wrap.
- Reset mid-SQUASH or mid-stall returns to RUN with the shadow cleared.
- Simultaneous hazard and taken branch: stall first; the branch resolves the next cycle with the forwarded-ready operands.

Test Plan:
- Reset: hold reset 5 cycles, mid-sequence → outputs 1,1,0,0,0; counters 0; shadow cleared (a following add x6,x5,x2 does not stall).
- Load-use: lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333) → exactly 1 cycle with pc_load=if_id_load=0, id_bubble=1, stall_count=1. Same pair with add rd=x0 source x0 → no stall.
- Branch taken: pc_in=0x20, beq x1,x2,+16 (0x00208863), rs1_data=rs2_data=7 → mux3_selector=1, pc_branch_in=0x30. Next cycle id_bubble=1, mux3_selector=0; flush_count=1.
- Branch not taken and signedness: same beq with 7 vs 8 → no redirect. blt with rs1=0xFFFFFFFF, rs2=1 → taken; bltu with the same operands → not taken.
- JAL backward with FLUSH_CYCLES=3: jal x0,-8 (0xFF9FF06F) at pc_in=0x100 → pc_branch_in=0xF8. Next 3 cycles id_bubble=1, with loads ignored during those cycles, then RUN.
- Saturation: CNT_W=2, 5 load-use stalls → stall_count holds 3.
